// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg: shared pipeline-control types for the hazard unit
package hazard_control_pkg;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_CSR} writebackType_;
  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} CSROp_;
  typedef enum logic [1:0] {RUN, MEM_WAIT, CSR_DRAIN, TRAP_FLUSH} hazardState_;
  localparam int unsigned DRAIN_CYCLES = 2;
endpackage

// File: rtl/hazard_control_perf_counter.sv
// perf_counter: free-running event counter, wraps at 2^W
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) count_q <= '0;
    else if (enable_i) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/hazard_control.sv
// hazard_control: pipeline stall/flush arbitration for memory waits, CSR drains, traps, branches and load-use
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [4:0]    fetchDecodeRegister1,
  input  logic [4:0]    fetchDecodeRegister2,
  input  logic [4:0]    decodeExecuteDestinationRegister,
  input  logic          decodeExecuteValid,
  input  writebackType_ decodeExecuteWritebackType,
  input  CSROp_         decodeExecuteCSROp,
  input  logic          executeBranchTaken,
  input  logic          trapRequest,
  input  logic          memoryRequest,
  input  logic          memoryReady,
  output logic          stallFetch,
  output logic          stallDecode,
  output logic          stallExecute,
  output logic          stallMemory,
  output logic          flushDecode,
  output logic          flushExecute,
  output logic          flushMemory,
  output logic          memoryTimeout,
  output logic [31:0]   stallCount
);
  hazardState_ state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  drain_q, drain_d;
  logic mem_stall, csr_hit, load_use, timeout;
  logic live, stall_all, run_free, branch, lu, drain, flushing, stall_fd;
  assign mem_stall = memoryRequest && !memoryReady;
  assign csr_hit   = decodeExecuteValid && decodeExecuteCSROp != CSR_NONE;
  assign load_use  = decodeExecuteValid && decodeExecuteWritebackType == WB_MEM &&
                     decodeExecuteDestinationRegister != 5'd0 &&
                     (decodeExecuteDestinationRegister == fetchDecodeRegister1 ||
                      decodeExecuteDestinationRegister == fetchDecodeRegister2);
  assign timeout   = state_q == MEM_WAIT && !trapRequest && !memoryReady &&
                     wait_q == 8'(WAIT_LIMIT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
    end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    if (trapRequest) state_d = TRAP_FLUSH;
    else
      case (state_q)
        RUN:
          if (mem_stall) begin
            state_d = MEM_WAIT;
            wait_d  = '0;
          end else if (!executeBranchTaken && csr_hit) begin
            state_d = CSR_DRAIN;
            drain_d = '0;
          end
        MEM_WAIT:
          if (memoryReady) state_d = RUN;
          else if (timeout) state_d = TRAP_FLUSH;
          else wait_d = wait_q + 8'd1;
        CSR_DRAIN:
          if (drain_q == 2'(DRAIN_CYCLES - 1)) state_d = RUN;
          else drain_d = drain_q + 2'd1;
        default: state_d = RUN;
      endcase
  end
  // A trap request silences every lower-priority action in its own cycle
  assign live      = !reset && !trapRequest;
  assign stall_all = live && ((state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !memoryReady));
  assign run_free  = live && state_q == RUN && !mem_stall;
  assign branch    = run_free && executeBranchTaken;
  assign lu        = run_free && !executeBranchTaken && !csr_hit && load_use;
  assign drain     = live && state_q == CSR_DRAIN;
  assign flushing  = !reset && state_q == TRAP_FLUSH;
  assign stall_fd  = stall_all || lu || drain;
  always_comb begin
    flushDecode   = branch || flushing;
    flushExecute  = branch || lu || flushing;
    flushMemory   = flushing;
    stallFetch    = stall_fd;
    stallDecode   = stall_fd && !flushDecode;
    stallExecute  = stall_all && !flushExecute;
    stallMemory   = stall_all && !flushMemory;
    memoryTimeout = !reset && timeout;
  end
  perf_counter #(.W(32)) u_stall_count (
    .clock_i (clock),
    .reset_i (reset),
    .enable_i(stallFetch || stallDecode || stallExecute || stallMemory),
    .count_o (stallCount)
  );
endmodule

// File: tb/tb_hazard_control.sv
// tb_hazard_control: directed scenarios with a scoreboard queue checked by an independent monitor
module tb_hazard_control;
  import hazard_control_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] r1, r2, dest;
  logic valid, br, trap, req, rdy;
  writebackType_ wb;
  CSROp_ csr;
  logic sf, sd, se, sm, fd, fe, fm, to;
  logic [31:0] cnt;
  always #5 clk = ~clk;
  hazard_control #(.WAIT_LIMIT(4)) dut (
    .clock(clk), .reset(rst),
    .fetchDecodeRegister1(r1), .fetchDecodeRegister2(r2),
    .decodeExecuteDestinationRegister(dest), .decodeExecuteValid(valid),
    .decodeExecuteWritebackType(wb), .decodeExecuteCSROp(csr),
    .executeBranchTaken(br), .trapRequest(trap),
    .memoryRequest(req), .memoryReady(rdy),
    .stallFetch(sf), .stallDecode(sd), .stallExecute(se), .stallMemory(sm),
    .flushDecode(fd), .flushExecute(fe), .flushMemory(fm),
    .memoryTimeout(to), .stallCount(cnt)
  );
  // Expected vector order: {sF,sD,sE,sM,fD,fE,fM,timeout}
  localparam logic [7:0] Z = 8'b0000_0000, ALL = 8'b1111_0000, LU = 8'b1100_0100,
                         BR = 8'b0000_1100, DR = 8'b1100_0000, TF = 8'b0000_1110,
                         TO = 8'b1111_0001;
  typedef struct {string nm; logic [7:0] e; logic [31:0] c;} exp_t;
  exp_t q[$];
  int pass = 0, total = 0;
  logic [31:0] exp_cnt = 0;
  task automatic chk(input logic [7:0] e, input string nm);
    exp_t x;
    if (rst) exp_cnt = 0;
    x.nm = nm; x.e = e; x.c = exp_cnt;
    q.push_back(x);
    if (|e[7:4]) exp_cnt = exp_cnt + 1;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    r1 = 0; r2 = 0; dest = 0; valid = 0; br = 0; trap = 0; req = 0; rdy = 0;
    wb = WB_NONE; csr = CSR_NONE;
  endtask
  initial begin
    exp_t x;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        got = {sf, sd, se, sm, fd, fe, fm, to};
        total++;
        if (got === x.e) pass++;
        else $display("FAIL %s flags got=%b exp=%b", x.nm, got, x.e);
        total++;
        if (cnt === x.c) pass++;
        else $display("FAIL %s stallCount got=%0d exp=%0d", x.nm, cnt, x.c);
      end
    end
  end
  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    chk(Z, "reset");
    rst = 0;
    chk(Z, "idle");
    valid = 1; wb = WB_MEM; dest = 5; r1 = 5;
    chk(LU, "lu_r1");
    valid = 0;
    chk(Z, "lu_after");
    valid = 1; r1 = 0; r2 = 5;
    chk(LU, "lu_r2");
    dest = 0; r2 = 0;
    chk(Z, "lu_x0");
    dest = 5; r1 = 5; wb = WB_ALU;
    chk(Z, "lu_alu");
    idle(); req = 1;
    chk(ALL, "mem_run");
    chk(ALL, "mem_w1");
    chk(ALL, "mem_w2");
    rdy = 1;
    chk(Z, "mem_rdy");
    idle();
    chk(Z, "mem_done");
    valid = 1; wb = WB_MEM; dest = 7; r2 = 7; br = 1;
    chk(BR, "br_lu");
    idle(); valid = 1; wb = WB_ALU; dest = 3; csr = CSR_RW;
    chk(Z, "csr_run");
    idle();
    chk(DR, "csr_d1");
    chk(DR, "csr_d2");
    chk(Z, "csr_done");
    valid = 1; csr = CSR_RS;
    chk(Z, "csr2_run");
    idle();
    chk(DR, "csr2_d1");
    trap = 1;
    chk(Z, "csr_trap");
    trap = 0;
    chk(TF, "trap_flush");
    chk(Z, "post_trap");
    req = 1;
    chk(ALL, "to_run");
    chk(ALL, "to_w1");
    chk(ALL, "to_w2");
    chk(ALL, "to_w3");
    chk(TO, "timeout");
    chk(TF, "to_flush");
    req = 0;
    chk(Z, "to_done");
    req = 1;
    chk(ALL, "rm_run");
    chk(ALL, "rm_w1");
    rst = 1;
    chk(Z, "rst_mid");
    rst = 0; req = 0;
    for (int i = 0; i < 5; i++) chk(Z, "rst_no_to");
    trap = 1; req = 1;
    chk(Z, "trap_prio");
    trap = 0; req = 0;
    chk(TF, "trap_prio_flush");
    chk(Z, "final");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
